// File: rtl/inst_mem.sv
// Instruction memory for the 16-bit CPU.
// Word-addressed storage with synchronous write and combinational (same-cycle) read.
// An optional synchronous reset clears the whole array in a single edge.
module inst_mem #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 12,
  parameter string       INIT_FILE    = "",
  parameter bit          CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_IM,
  input  logic [DATA_W-1:0] dataIM,
  input  logic [ADDR_W-1:0] addIM,
  output logic [DATA_W-1:0] outIM
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Power-up contents: all zeros, keeping outIM free of X before the first reset.
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
    end
  end

  // Reset wins over a write; with clearing disabled, reset just drops the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RST) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem[ADDR_W'(i)] <= '0;
        end
      end
    end else if (we_IM == 1'b1) begin
      mem[addIM] <= dataIM;
    end
  end

  // No bypass: a same-cycle write becomes visible only after the edge.
  assign outIM = mem[addIM];

endmodule

// File: tb/tb_inst_mem.sv
// Self-checking bench for inst_mem: one instance clears on reset, one keeps contents.
module tb_inst_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we_IM = 1'b0;
  logic [15:0] dataIM = '0;
  logic [11:0] addIM = '0;
  logic [15:0] out_clr;
  logic [15:0] out_keep;

  int total = 0;
  int bad   = 0;

  // Reference contents for each instance.
  logic [15:0] m_clr  [4096];
  logic [15:0] m_keep [4096];

  typedef struct {
    logic        r;
    logic        w;
    logic [15:0] d;
    logic [11:0] a;
    logic [15:0] pre_clr;
    logic [15:0] post_clr;
    logic [15:0] pre_keep;
    logic [15:0] post_keep;
  } vec_t;

  vec_t tbl [18];

  inst_mem #(
    .DATA_W      (16),
    .ADDR_W      (12),
    .INIT_FILE   (""),
    .CLEAR_ON_RST(1'b1)
  ) u_clr (
    .clk   (clk),
    .rst   (rst),
    .we_IM (we_IM),
    .dataIM(dataIM),
    .addIM (addIM),
    .outIM (out_clr)
  );

  inst_mem #(
    .DATA_W      (16),
    .ADDR_W      (12),
    .INIT_FILE   (""),
    .CLEAR_ON_RST(1'b0)
  ) u_keep (
    .clk   (clk),
    .rst   (rst),
    .we_IM (we_IM),
    .dataIM(dataIM),
    .addIM (addIM),
    .outIM (out_keep)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive mid-cycle, check before the edge, check after the edge.
  task automatic cycle(input string name, input logic r, input logic w, input logic [15:0] d,
                       input logic [11:0] a, input logic [15:0] pre_c, input logic [15:0] post_c,
                       input logic [15:0] pre_k, input logic [15:0] post_k);
    @(negedge clk);
    rst = r; we_IM = w; dataIM = d; addIM = a;
    #1;
    check({name, " pre clr"}, out_clr, pre_c);
    check({name, " pre keep"}, out_keep, pre_k);
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 4096; k++) m_clr[k] = '0;
    end else if (w) begin
      m_clr[a]  = d;
      m_keep[a] = d;
    end
    #1;
    check({name, " post clr"}, out_clr, post_c);
    check({name, " post keep"}, out_keep, post_k);
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) begin
      m_clr[k]  = '0;
      m_keep[k] = '0;
    end

    //          r  w  data      addr     pre_c     post_c    pre_k     post_k
    tbl[0]  = '{1, 0, 16'h0000, 12'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[1]  = '{0, 1, 16'h1234, 12'h002, 16'h0000, 16'h1234, 16'h0000, 16'h1234};
    tbl[2]  = '{0, 0, 16'h0000, 12'h002, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
    tbl[3]  = '{0, 1, 16'hABCD, 12'h00A, 16'h0000, 16'hABCD, 16'h0000, 16'hABCD};
    tbl[4]  = '{0, 0, 16'h0000, 12'h002, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
    tbl[5]  = '{0, 1, 16'h5555, 12'h00A, 16'hABCD, 16'h5555, 16'hABCD, 16'h5555};
    tbl[6]  = '{0, 1, 16'h0077, 12'h003, 16'h0000, 16'h0077, 16'h0000, 16'h0077};
    tbl[7]  = '{1, 1, 16'hFFFF, 12'h003, 16'h0077, 16'h0000, 16'h0077, 16'h0077};
    tbl[8]  = '{0, 0, 16'h0000, 12'h002, 16'h0000, 16'h0000, 16'h1234, 16'h1234};
    tbl[9]  = '{0, 0, 16'h0000, 12'h00A, 16'h0000, 16'h0000, 16'h5555, 16'h5555};
    tbl[10] = '{1, 0, 16'h0000, 12'hFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[11] = '{1, 1, 16'h9999, 12'h00A, 16'h0000, 16'h0000, 16'h5555, 16'h5555};
    tbl[12] = '{0, 1, 16'hBEEF, 12'hFFF, 16'h0000, 16'hBEEF, 16'h0000, 16'hBEEF};
    tbl[13] = '{0, 1, 16'hCAFE, 12'h000, 16'h0000, 16'hCAFE, 16'h0000, 16'hCAFE};
    tbl[14] = '{0, 0, 16'h0000, 12'hFFE, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[15] = '{0, 0, 16'h0000, 12'h001, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[16] = '{0, 0, 16'h0000, 12'hFFF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    tbl[17] = '{0, 0, 16'h0000, 12'h000, 16'hCAFE, 16'hCAFE, 16'hCAFE, 16'hCAFE};

    // Power-up contents are all zero and not X.
    addIM = 12'h123;
    #1;
    check("powerup 123 clr", out_clr, 16'h0000);
    check("powerup 123 keep", out_keep, 16'h0000);
    addIM = 12'hFFF;
    #1;
    check("powerup FFF keep", out_keep, 16'h0000);

    // Reset leaves 0x002 and 0xFFF at zero too.
    cycle("rst0", 1'b1, 1'b0, 16'h0, 12'h000, 16'h0, 16'h0, 16'h0, 16'h0);
    cycle("rst002", 1'b1, 1'b0, 16'h0, 12'h002, 16'h0, 16'h0, 16'h0, 16'h0);
    cycle("rstFFF", 1'b1, 1'b0, 16'h0, 12'hFFF, 16'h0, 16'h0, 16'h0, 16'h0);

    for (int i = 0; i < 18; i++) begin
      cycle($sformatf("vec%0d", i), tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].a,
            tbl[i].pre_clr, tbl[i].post_clr, tbl[i].pre_keep, tbl[i].post_keep);
    end

    // Address change inside one cycle must show up without waiting for an edge.
    @(negedge clk);
    rst = 1'b0; we_IM = 1'b0; addIM = 12'hFFF;
    #1;
    check("comb FFF", out_clr, 16'hBEEF);
    addIM = 12'h000;
    #1;
    check("comb 000", out_clr, 16'hCAFE);

    // Random traffic on a small address window so reads hit written words.
    for (int n = 0; n < 400; n++) begin
      logic        r;
      logic        w;
      logic [15:0] d;
      logic [11:0] a;
      logic [15:0] pc, pk;
      r = ($urandom_range(0, 39) == 0);
      w = $urandom_range(0, 1) == 1;
      d = 16'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
      if (r) begin
        pc = 16'h0000;
        pk = m_keep[a];
      end else if (w) begin
        pc = d;
        pk = d;
      end else begin
        pc = m_clr[a];
        pk = m_keep[a];
      end
      cycle($sformatf("rnd%0d", n), r, w, d, a, m_clr[a], pc, m_keep[a], pk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
